// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants for the 5-stage MIPS core.
// Used by the IF stage and its IF/ID register.
package pipe_pkg;

  localparam int PC_W   = 9;
  localparam int INST_W = 32;

  localparam logic [INST_W-1:0] NOP              = 32'h0000_0020;
  localparam logic [PC_W-1:0]   RESET_PC_DEFAULT = 9'h000;

  typedef enum logic {
    BOOT  = 1'b0,
    FETCH = 1'b1
  } if_state_t;

  // Sequential fetch address; the natural 9-bit wrap takes 9'h1FC to 9'h000.
  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
    return pc + PC_W'(4);
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: bubble beats hold beats load, the same
// flush-over-stall policy as the ID/EX register.
module if_id_reg
  import pipe_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              bubble_i,
  input  logic              hold_i,
  input  logic [PC_W-1:0]   pc_4_i,
  input  logic [INST_W-1:0] inst_i,
  output logic [PC_W-1:0]   pc_4_o,
  output logic [INST_W-1:0] inst_o,
  output logic              valid_o
);

  logic [PC_W-1:0]   pc_4_q;
  logic [INST_W-1:0] inst_q;
  logic              valid_q;

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_4_q  <= '0;
      inst_q  <= NOP;
      valid_q <= 1'b0;
    end else if (bubble_i) begin
      pc_4_q  <= '0;
      inst_q  <= NOP;
      valid_q <= 1'b0;
    end else if (!hold_i && load_i) begin
      pc_4_q  <= pc_4_i;
      inst_q  <= inst_i;
      valid_q <= 1'b1;
    end
  end

  assign pc_4_o  = pc_4_q;
  assign inst_o  = inst_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, BOOT/FETCH handshake to imem, IF/ID register.
// Optional IF_PERF_CNT_EN adds saturating fetch_cnt / bubble_cnt outputs.
module if_stage
  import pipe_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ready,
  input  logic [INST_W-1:0] imem_rdata,
  output logic [PC_W-1:0]   ID_pc_4,
  output logic [INST_W-1:0] ID_inst,
  output logic              ID_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_cnt,
  output logic [31:0]       bubble_cnt
`endif
);

  if_state_t       state_q;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pc_plus4;
  logic            fetch_done;
  logic            ifid_bubble;
  logic            unused_ok;

  // Target is word-aligned by construction; the low bits are dropped.
  assign unused_ok = ^redirect_pc[1:0];

  assign pc_plus4   = pc_inc(pc_q);
  assign imem_req   = (state_q == FETCH) && !stall && !redirect;
  assign imem_addr  = pc_q;
  assign fetch_done = imem_req && imem_ready;

  // Anything that is neither a held stall nor a completed fetch drains to a bubble.
  assign ifid_bubble = redirect || flush || (!stall && !fetch_done);

  // NOTE: assign a default first so every path drives pc_d and no latch is inferred.
  always_comb begin
    pc_d = pc_q;
    if (redirect) begin
      pc_d = {redirect_pc[PC_W-1:2], 2'b00};
    end else if (fetch_done) begin
      pc_d = pc_plus4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= FETCH;
      pc_q    <= pc_d;
    end
  end

  if_id_reg u_if_id_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (fetch_done),
    .bubble_i (ifid_bubble),
    .hold_i   (stall),
    .pc_4_i   (pc_plus4),
    .inst_i   (imem_rdata),
    .pc_4_o   (ID_pc_4),
    .inst_o   (ID_inst),
    .valid_o  (ID_valid)
  );

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] bubble_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (fetch_done && (fetch_cnt_q != '1)) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (ifid_bubble && (bubble_cnt_q != '1)) begin
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
      end
    end
  end

  assign fetch_cnt  = fetch_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        redirect = 1'b0;
  logic [8:0]  redirect_pc = 9'h000;
  logic        imem_ready = 1'b1;
  logic        imem_req;
  logic [8:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic [8:0]  ID_pc_4;
  logic [31:0] ID_inst;
  logic        ID_valid;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] bubble_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  // Address-tagged memory contents; never equal to the bubble word.
  function automatic logic [31:0] tag(input logic [8:0] a);
    return 32'hC0DE_0000 | {23'd0, a};
  endfunction

  assign imem_rdata = imem_ready ? tag(imem_addr) : 32'hDEAD_BEEF;

  if_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .flush       (flush),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .ID_pc_4     (ID_pc_4),
    .ID_inst     (ID_inst),
    .ID_valid    (ID_valid)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_cnt   (fetch_cnt),
    .bubble_cnt  (bubble_cnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what the fetch stage must hold after each edge.
  logic [8:0]  m_pc;
  logic        m_booted;
  logic [8:0]  m_pc4;
  logic [31:0] m_inst;
  logic        m_valid;
  logic [31:0] m_fc;
  logic [31:0] m_bc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc <= 9'h000; m_booted <= 1'b0;
      m_pc4 <= 9'h000; m_inst <= 32'h20; m_valid <= 1'b0;
      m_fc <= 0; m_bc <= 0;
    end else begin
      m_booted <= 1'b1;
      if (redirect) begin
        m_pc <= redirect_pc & 9'h1FC;
        m_pc4 <= 9'h000; m_inst <= 32'h20; m_valid <= 1'b0;
        m_bc <= (m_bc == 32'hFFFF_FFFF) ? m_bc : m_bc + 1;
      end else if (stall) begin
        if (flush) begin
          m_pc4 <= 9'h000; m_inst <= 32'h20; m_valid <= 1'b0;
          m_bc <= (m_bc == 32'hFFFF_FFFF) ? m_bc : m_bc + 1;
        end
      end else if (m_booted && imem_ready) begin
        m_pc <= 9'((m_pc + 4) % 512);
        m_fc <= (m_fc == 32'hFFFF_FFFF) ? m_fc : m_fc + 1;
        if (flush) begin
          m_pc4 <= 9'h000; m_inst <= 32'h20; m_valid <= 1'b0;
          m_bc <= (m_bc == 32'hFFFF_FFFF) ? m_bc : m_bc + 1;
        end else begin
          m_pc4 <= 9'((m_pc + 4) % 512); m_inst <= tag(m_pc); m_valid <= 1'b1;
        end
      end else begin
        m_pc4 <= 9'h000; m_inst <= 32'h20; m_valid <= 1'b0;
        m_bc <= (m_bc == 32'hFFFF_FFFF) ? m_bc : m_bc + 1;
      end
    end
  end

  // Compare process: outputs are stable mid-cycle, inputs change just after posedge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("imem_req", {31'd0, imem_req}, {31'd0, m_booted && !stall && !redirect});
      check("imem_addr", {23'd0, imem_addr}, {23'd0, m_pc});
      check("ID_pc_4", {23'd0, ID_pc_4}, {23'd0, m_pc4});
      check("ID_inst", ID_inst, m_inst);
      check("ID_valid", {31'd0, ID_valid}, {31'd0, m_valid});
`ifdef IF_PERF_CNT_EN
      check("fetch_cnt", fetch_cnt, m_fc);
      check("bubble_cnt", bubble_cnt, m_bc);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] bc_snap;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("rst_imem_req", {31'd0, imem_req}, 32'd0);
    check("rst_imem_addr", {23'd0, imem_addr}, 32'h000);
    check("rst_ID_valid", {31'd0, ID_valid}, 32'd0);
    check("rst_ID_inst", ID_inst, 32'h0000_0020);
    check("rst_ID_pc_4", {23'd0, ID_pc_4}, 32'd0);
    rst_n = 1'b1;

    // First edge leaves BOOT and loads a bubble.
    tick();
    check("boot_ID_valid", {31'd0, ID_valid}, 32'd0);
    check("boot_ID_inst", ID_inst, 32'h0000_0020);
    check("boot_imem_req", {31'd0, imem_req}, 32'd1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("seq_ID_valid", {31'd0, ID_valid}, 32'd1);
      check("seq_ID_pc_4", {23'd0, ID_pc_4}, 32'(4 * k));
      check("seq_ID_inst", ID_inst, tag(9'(4 * (k - 1))));
      check("seq_imem_addr", {23'd0, imem_addr}, 32'(4 * k));
    end

    // Redirect while fetching from 0x010.
    redirect = 1'b1; redirect_pc = 9'h0A3;
    #1 check("redir_imem_req", {31'd0, imem_req}, 32'd0);
    tick();
    redirect = 1'b0;
    check("redir_bubble", {31'd0, ID_valid}, 32'd0);
    check("redir_addr", {23'd0, imem_addr}, 32'h0A0);
    tick();
    check("redir_target_pc4", {23'd0, ID_pc_4}, 32'h0A4);
    check("redir_target_inst", ID_inst, tag(9'h0A0));

    // Three wait states at 0x020.
    redirect = 1'b1; redirect_pc = 9'h020;
    tick();
    redirect = 1'b0; imem_ready = 1'b0;
    bc_snap = m_bc;
    repeat (3) begin
      tick();
      check("wait_addr", {23'd0, imem_addr}, 32'h020);
      check("wait_bubble", {31'd0, ID_valid}, 32'd0);
    end
`ifdef IF_PERF_CNT_EN
    check("wait_bubble_cnt", bubble_cnt, bc_snap + 32'd3);
`endif
    imem_ready = 1'b1;
    tick();
    check("wait_done_pc4", {23'd0, ID_pc_4}, 32'h024);
    check("wait_done_inst", ID_inst, tag(9'h020));

    // Plain stall, then stall with flush.
    stall = 1'b1;
    #1 check("stall_req", {31'd0, imem_req}, 32'd0);
    repeat (2) tick();
    check("stall_addr", {23'd0, imem_addr}, 32'h024);
    check("stall_pc4", {23'd0, ID_pc_4}, 32'h024);
    check("stall_valid", {31'd0, ID_valid}, 32'd1);
    stall = 1'b0;
    tick();
    check("unstall_pc4", {23'd0, ID_pc_4}, 32'h028);
    stall = 1'b1; flush = 1'b1;
    tick();
    check("sflush_valid", {31'd0, ID_valid}, 32'd0);
    check("sflush_inst", ID_inst, 32'h0000_0020);
    check("sflush_addr", {23'd0, imem_addr}, 32'h028);
    stall = 1'b0; flush = 1'b0;

    // PC wrap at 0x1FC, then reset in the middle of a wait.
    redirect = 1'b1; redirect_pc = 9'h1FC;
    tick();
    redirect = 1'b0;
    tick();
    check("wrap_pc4", {23'd0, ID_pc_4}, 32'h000);
    check("wrap_addr", {23'd0, imem_addr}, 32'h000);
    tick();
    imem_ready = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst_addr", {23'd0, imem_addr}, 32'h000);
    check("arst_req", {31'd0, imem_req}, 32'd0);
    check("arst_valid", {31'd0, ID_valid}, 32'd0);
    check("arst_inst", ID_inst, 32'h0000_0020);
    check("arst_pc4", {23'd0, ID_pc_4}, 32'd0);
`ifdef IF_PERF_CNT_EN
    check("arst_fetch_cnt", fetch_cnt, 32'd0);
    check("arst_bubble_cnt", bubble_cnt, 32'd0);
`endif
    tick();
    imem_ready = 1'b1;
    rst_n = 1'b1;

    // Randomized traffic, including occasional asynchronous reset pulses.
    repeat (3000) begin
      tick();
      imem_ready  = ($urandom_range(0, 3) != 0);
      stall       = ($urandom_range(0, 6) == 0);
      flush       = ($urandom_range(0, 9) == 0);
      redirect    = ($urandom_range(0, 11) == 0);
      redirect_pc = 9'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
